// File: rtl/ts_stub_pair_sequencer_pkg.sv
//------------------------------------------------------------------------------
// ts_stub_pair_sequencer_pkg : shared widths and FSM encoding for the sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ts_stub_pair_sequencer_pkg;

  localparam int STUB_X_PHY_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/ts_stub_pair_sequencer_limits.sv
//------------------------------------------------------------------------------
// ts_x_window_limits : saturated x-window limits around an inner-stub x
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ts_x_window_limits
  import ts_stub_pair_sequencer_pkg::*;
#(
  parameter int X_BITS = STUB_X_PHY_BITS
) (
  input  logic signed [X_BITS-1:0] in_x_i,
  input  logic        [X_BITS-2:0] win_plus_i,
  input  logic        [X_BITS-2:0] win_minus_i,
  output logic signed [X_BITS-1:0] lim_plus_o,
  output logic signed [X_BITS-1:0] lim_minus_o
);

  localparam logic signed [X_BITS:0] C_MAX = {2'b00, {(X_BITS-1){1'b1}}};
  localparam logic signed [X_BITS:0] C_MIN = {2'b11, {(X_BITS-1){1'b0}}};

  logic signed [X_BITS:0] sum_w;
  logic signed [X_BITS:0] dif_w;

  // One guard bit is enough: half-widths are strictly narrower than x.
  assign sum_w = {in_x_i[X_BITS-1], in_x_i} + {2'b00, win_plus_i};
  assign dif_w = {in_x_i[X_BITS-1], in_x_i} - {2'b00, win_minus_i};

  assign lim_plus_o  = (sum_w > C_MAX) ? C_MAX[X_BITS-1:0] : sum_w[X_BITS-1:0];
  assign lim_minus_o = (dif_w < C_MIN) ? C_MIN[X_BITS-1:0] : dif_w[X_BITS-1:0];

endmodule

`default_nettype wire

// File: rtl/ts_stub_pair_sequencer.sv
//------------------------------------------------------------------------------
// ts_stub_pair_sequencer : buffers outer stubs, sweeps them per inner stub into
// the x-window comparator and emits tagged matched pairs. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ts_stub_pair_sequencer
  import ts_stub_pair_sequencer_pkg::*;
#(
  parameter int X_BITS  = STUB_X_PHY_BITS,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ID_BITS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      out_wr_en_i,
  input  logic signed [X_BITS-1:0]  out_wr_dat_i,
  input  logic                      out_clear_i,
  output logic                      out_full_o,
  output logic                      wr_drop_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic signed [X_BITS-1:0]  in_x_i,
  input  logic        [ID_BITS-1:0] in_id_i,
  input  logic        [X_BITS-2:0]  win_plus_i,
  input  logic        [X_BITS-2:0]  win_minus_i,
  output logic                      cmp_valid_o,
  output logic signed [X_BITS-1:0]  cmp_stub_dat_o,
  output logic signed [X_BITS-1:0]  cmp_lim_plus_o,
  output logic signed [X_BITS-1:0]  cmp_lim_minus_o,
  input  logic                      cmp_match_i,
  output logic                      pair_valid_o,
  output logic        [ID_BITS-1:0] pair_in_id_o,
  output logic        [AW-1:0]      pair_out_idx_o,
  output logic                      done_o,
  output logic        [AW:0]        done_nmatch_o
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  seq_state_e               state_q, state_d;
  logic        [AW:0]       count_q, count_d;
  logic        [AW-1:0]     k_q, k_d;
  logic signed [X_BITS-1:0] mem_q [DEPTH];
  logic signed [X_BITS-1:0] lim_plus_d, lim_minus_d;
  logic signed [X_BITS-1:0] lim_plus_q, lim_minus_q;
  logic        [ID_BITS-1:0] id_q;
  logic                     iss_v_q;
  logic        [AW-1:0]     iss_idx_q;
  logic                     pair_valid_q;
  logic        [ID_BITS-1:0] pair_id_q;
  logic        [AW-1:0]     pair_idx_q;
  logic        [AW:0]       nmatch_q;
  logic                     wr_drop_q, wr_drop_d;

  logic          idle, accept, full, wr_do, hit;
  logic [AW-1:0] wr_addr;

  assign idle       = (state_q == ST_IDLE);
  assign full       = (count_q == C_DEPTH);
  assign in_ready_o = idle & ~rst;
  assign accept     = in_valid_i & in_ready_o;
  assign hit        = iss_v_q & cmp_match_i;

  ts_x_window_limits #(
    .X_BITS (X_BITS)
  ) u_limits (
    .in_x_i      (in_x_i),
    .win_plus_i  (win_plus_i),
    .win_minus_i (win_minus_i),
    .lim_plus_o  (lim_plus_d),
    .lim_minus_o (lim_minus_d)
  );

  // Clear wins over a same-cycle write, so the write then lands at slot 0.
  always_comb begin
    wr_do     = 1'b0;
    wr_addr   = count_q[AW-1:0];
    count_d   = count_q;
    wr_drop_d = 1'b0;
    if (idle) begin
      if (out_clear_i) begin
        wr_addr = '0;
        wr_do   = out_wr_en_i;
        count_d = out_wr_en_i ? (AW+1)'(1) : '0;
      end else if (out_wr_en_i) begin
        wr_do     = ~full;
        wr_drop_d = full;
        count_d   = full ? count_q : count_q + (AW+1)'(1);
      end
    end else begin
      wr_drop_d = out_wr_en_i | out_clear_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do && !rst) begin
      mem_q[wr_addr] <= out_wr_dat_i;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          k_d     = '0;
          state_d = (count_d != '0) ? ST_SWEEP : ST_DONE;
        end
      end
      ST_SWEEP: begin
        if ({1'b0, k_q} == count_q - (AW+1)'(1)) begin
          state_d = ST_WAIT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ST_WAIT: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      k_q          <= '0;
      lim_plus_q   <= '0;
      lim_minus_q  <= '0;
      id_q         <= '0;
      iss_v_q      <= 1'b0;
      iss_idx_q    <= '0;
      pair_valid_q <= 1'b0;
      pair_id_q    <= '0;
      pair_idx_q   <= '0;
      nmatch_q     <= '0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      k_q       <= k_d;
      wr_drop_q <= wr_drop_d;
      if (accept) begin
        lim_plus_q  <= lim_plus_d;
        lim_minus_q <= lim_minus_d;
        id_q        <= in_id_i;
      end
      // Issued index trails by one cycle to line up with the comparator result.
      iss_v_q      <= cmp_valid_o;
      iss_idx_q    <= k_q;
      pair_valid_q <= hit;
      pair_id_q    <= hit ? id_q : '0;
      pair_idx_q   <= hit ? iss_idx_q : '0;
      if (accept) begin
        nmatch_q <= '0;
      end else if (hit) begin
        nmatch_q <= nmatch_q + (AW+1)'(1);
      end
    end
  end

  assign out_full_o      = full;
  assign wr_drop_o       = wr_drop_q;
  assign cmp_valid_o     = (state_q == ST_SWEEP);
  assign cmp_stub_dat_o  = cmp_valid_o ? mem_q[k_q] : '0;
  assign cmp_lim_plus_o  = lim_plus_q;
  assign cmp_lim_minus_o = lim_minus_q;
  assign pair_valid_o    = pair_valid_q;
  assign pair_in_id_o    = pair_id_q;
  assign pair_out_idx_o  = pair_idx_q;
  assign done_o          = (state_q == ST_DONE);
  assign done_nmatch_o   = done_o ? nmatch_q : '0;

endmodule

`default_nettype wire
